uart_frame_scheduler: RTL and testbench

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

---
 rtl/uart_frame_scheduler_pkg.sv | 28 ++
 rtl/uart_sched_arbiter.sv | 42 ++++
 rtl/uart_frame_scheduler.sv | 141 ++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler.
// Contents: FSM state encoding, default sample width, frames counter width,
// channel index width, and counter-width helpers.
package uart_frame_scheduler_pkg;

   localparam int unsigned DEFAULT_DATA_W = 22;
   localparam int unsigned FRAMES_W       = 16;
   localparam int unsigned CHAN_W         = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } sched_state_e;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index n channels (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_sched_arbiter.sv
// Channel grant selection for the UART frame scheduler.
// Searches the request vector starting at ptr+1 (mod NUM_CH) and returns the
// first requester as a one-hot grant plus its index. Holding ptr at NUM_CH-1
// turns this into fixed lowest-index-first priority.
// Ports:
//   req   [NUM_CH-1:0] in  : per-channel requests
//   ptr   [IDX_W-1:0]  in  : last granted channel
//   grant [NUM_CH-1:0] out : one-hot grant (zero when no request), combinational
//   idx   [IDX_W-1:0]  out : index of the granted channel, combinational
module uart_sched_arbiter #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned IDX_W  = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [IDX_W-1:0]  idx
);

   logic [NUM_CH-1:0] req_rot;
   int unsigned       cand;
   logic              found;

   // Rotating first-match search.
   always_comb begin
      grant   = '0;
      idx     = '0;
      found   = 1'b0;
      cand    = 0;
      req_rot = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         cand    = (32'(ptr) + 32'd1 + k) % NUM_CH;
         req_rot = req >> cand;
         if (!found && req_rot[0]) begin
            found = 1'b1;
            grant = NUM_CH'(1) << cand;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_frame_scheduler.sv
// UART frame scheduler: arbitrates per-channel sample requests and sequences
// one frame at a time into a UART driver (issue, wait busy, wait done, gap).
// Optional feature: define UART_SCHED_ROUND_ROBIN_EN for round-robin grants;
// otherwise fixed priority, lowest channel index first.
// Ports:
//   sys_clock   in  : clock, rising edge
//   reset       in  : synchronous active-high reset
//   req_valid   in  [NUM_CH]        : per-channel sample available
//   req_data    in  [NUM_CH*DATA_W] : channel i at [i*DATA_W +: DATA_W]
//   req_ready   out [NUM_CH]        : combinational accept, one-hot in IDLE
//   drv_busy    in  : driver serializing a frame
//   new_frame   out : one-cycle frame start strobe (ISSUE state)
//   o_data      out [DATA_W] : frame payload
//   o_chan      out [2]      : frame channel index
//   timeout_err out : sticky, driver never raised busy
//   frames_sent out [16]     : completed frame count, wraps
module uart_frame_scheduler
   import uart_frame_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH       = 3,
   parameter int unsigned DATA_W       = DEFAULT_DATA_W,
   parameter int unsigned GAP_CYCLES   = 16,
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic                     sys_clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic                     drv_busy,
   output logic                     new_frame,
   output logic [DATA_W-1:0]        o_data,
   output logic [CHAN_W-1:0]        o_chan,
   output logic                     timeout_err,
   output logic [FRAMES_W-1:0]      frames_sent
);

   localparam int unsigned IDX_W = idx_width(NUM_CH);
   localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
   localparam int unsigned TMO_W = cnt_width(BUSY_TIMEOUT);

   sched_state_e      state, state_next;
   logic [NUM_CH-1:0] grant;
   logic [IDX_W-1:0]  grant_idx;
   logic [IDX_W-1:0]  arb_ptr;
   logic [DATA_W-1:0] sel_data;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              take;
   logic              gap_last;
   logic              tmo_last;

   uart_sched_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_arbiter (
      .req   (req_valid),
      .ptr   (arb_ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

`ifdef UART_SCHED_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_grant;

   // Pointer moves only on an accepted grant; reset value makes ch0 first.
   always_ff @(posedge sys_clock) begin
      if (reset)     last_grant <= IDX_W'(NUM_CH - 1);
      else if (take) last_grant <= grant_idx;
   end
   assign arb_ptr = last_grant;
`else
   assign arb_ptr = IDX_W'(NUM_CH - 1);
`endif

   // Mux the granted channel's sample.
   always_comb begin
      sel_data = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (grant[c]) sel_data = sel_data | req_data[c*DATA_W +: DATA_W];
      end
   end

   // Reset gates the grant so no handshake can occur while reset is held.
   assign take     = (state == IDLE) && (|req_valid) && !reset;
   // A zero length still yields a single GAP cycle.
   assign gap_last = (32'(gap_cnt) + 32'd1) >= GAP_CYCLES;
   assign tmo_last = (32'(tmo_cnt) + 32'd1) >= BUSY_TIMEOUT;

   // State register.
   always_ff @(posedge sys_clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (take) begin
               req_ready  = grant;
               state_next = ISSUE;
            end
         end
         ISSUE:     state_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (drv_busy)      state_next = WAIT_DONE;
            else if (tmo_last) state_next = GAP;
         end
         WAIT_DONE: if (!drv_busy) state_next = GAP;
         GAP:       if (gap_last)  state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Frame payload, strobe, counters and status.
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         new_frame   <= 1'b0;
         o_data      <= '0;
         o_chan      <= '0;
         timeout_err <= 1'b0;
         frames_sent <= '0;
         gap_cnt     <= '0;
         tmo_cnt     <= '0;
      end else begin
         new_frame <= (state_next == ISSUE);
         if (take) begin
            o_data <= sel_data;
            o_chan <= CHAN_W'(grant_idx);
         end
         if (state == WAIT_BUSY && !drv_busy && tmo_last) timeout_err <= 1'b1;
         if (state == WAIT_DONE && !drv_busy) frames_sent <= frames_sent + 1'b1;
         gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + 1'b1 : '0;
         tmo_cnt <= (state == WAIT_BUSY && !drv_busy) ? tmo_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed self-checking bench for uart_frame_scheduler (default parameters).
module tb_uart_frame_scheduler;

   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DATA_W = 22;

   localparam logic [DATA_W-1:0] D0 = 22'h2AAAAA;
   localparam logic [DATA_W-1:0] D1 = 22'h0F0F0F;
   localparam logic [DATA_W-1:0] D2 = 22'h155555;

   logic                     sys_clock = 1'b0;
   logic                     reset     = 1'b1;
   logic [NUM_CH-1:0]        req_valid = '0;
   logic [NUM_CH*DATA_W-1:0] req_data;
   logic [NUM_CH-1:0]        req_ready;
   logic                     drv_busy  = 1'b0;
   logic                     new_frame;
   logic [DATA_W-1:0]        o_data;
   logic [1:0]               o_chan;
   logic                     timeout_err;
   logic [15:0]              frames_sent;

   int total = 0;
   int bad   = 0;

   uart_frame_scheduler dut (
      .sys_clock   (sys_clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .drv_busy    (drv_busy),
      .new_frame   (new_frame),
      .o_data      (o_data),
      .o_chan      (o_chan),
      .timeout_err (timeout_err),
      .frames_sent (frames_sent)
   );

   always #5 sys_clock = ~sys_clock;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      drv_busy  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Returns cycles waited until req_ready is nonzero, or -1 on expiry.
   // Leaves the caller at the falling edge of the grant cycle.
   task automatic wait_grant(input int max_cycles, output int waited);
      int n;
      logic done;
      waited = -1;
      n      = 0;
      done   = 1'b0;
      while (!done && n < max_cycles) begin
         @(negedge sys_clock);
         if (req_ready != '0) begin
            waited = n;
            done   = 1'b1;
         end else begin
            tick();
            n++;
         end
      end
   endtask

   // Called in the ISSUE cycle; ends just after the edge entering GAP.
   task automatic handshake_from_issue(input int busy_cycles);
      tick();
      drv_busy = 1'b1;
      tick();
      repeat (busy_cycles - 1) tick();
      drv_busy = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '0;
      drv_busy  = 1'b0;
      repeat (2) tick();
      @(negedge sys_clock);
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b want=000", req_ready); end
      total++; if (new_frame !== 1'b0) begin bad++; $display("FAIL rst_new_frame got=%b want=0", new_frame); end
      total++; if (o_data !== 22'h0) begin bad++; $display("FAIL rst_o_data got=%h want=0", o_data); end
      total++; if (o_chan !== 2'd0) begin bad++; $display("FAIL rst_o_chan got=%0d want=0", o_chan); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout_err); end
      total++; if (frames_sent !== 16'h0) begin bad++; $display("FAIL rst_frames got=%h want=0", frames_sent); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single();
      int gap_zero;
      logic seen;
      do_reset();
      req_valid = 3'b010;
      @(negedge sys_clock);
      total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b want=010", req_ready); end
      total++; if (new_frame !== 1'b0) begin bad++; $display("FAIL single_nf_early got=%b want=0", new_frame); end
      tick();
      req_valid = 3'b000;
      @(negedge sys_clock);
      total++; if (new_frame !== 1'b1) begin bad++; $display("FAIL single_new_frame got=%b want=1", new_frame); end
      total++; if (o_data !== D1) begin bad++; $display("FAIL single_o_data got=%h want=%h", o_data, D1); end
      total++; if (o_chan !== 2'd1) begin bad++; $display("FAIL single_o_chan got=%0d want=1", o_chan); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL single_ready_issue got=%b want=000", req_ready); end
      tick();
      @(negedge sys_clock);
      total++; if (new_frame !== 1'b0) begin bad++; $display("FAIL single_nf_pulse got=%b want=0", new_frame); end
      tick();
      drv_busy = 1'b1;
      repeat (100) tick();
      drv_busy  = 1'b0;
      req_valid = 3'b100;
      @(negedge sys_clock);
      total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL hs_frames_busy got=%0d want=0", frames_sent); end
      total++; if (o_data !== D1) begin bad++; $display("FAIL hs_data_stable got=%h want=%h", o_data, D1); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL hs_ready_done got=%b want=000", req_ready); end
      tick();
      @(negedge sys_clock);
      total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL hs_frames got=%0d want=1", frames_sent); end
      gap_zero = (req_ready == '0) ? 1 : 0;
      seen     = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         @(negedge sys_clock);
         if (req_ready != '0) seen = 1'b1;
         else gap_zero++;
      end
      total++; if (!seen || gap_zero != 16) begin bad++; $display("FAIL hs_gap_len got=%0d seen=%b want=16", gap_zero, seen); end
      total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL hs_next_grant got=%b want=100", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_contention();
      int w;
      int exp_ch;
      logic [2:0] exp_rdy;
      do_reset();
      req_valid = 3'b111;
      for (int f = 0; f < 6; f++) begin
`ifdef UART_SCHED_ROUND_ROBIN_EN
         exp_ch = f % 3;
`else
         exp_ch = 0;
`endif
         exp_rdy = 3'b001 << exp_ch;
         wait_grant(60, w);
         total++; if (w < 0) begin bad++; $display("FAIL cont_wait frame=%0d got=timeout want=grant", f); end
         total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL cont_grant frame=%0d got=%b want=%b", f, req_ready, exp_rdy); end
         tick();
         @(negedge sys_clock);
         total++; if (o_chan !== 2'(exp_ch)) begin bad++; $display("FAIL cont_chan frame=%0d got=%0d want=%0d", f, o_chan, exp_ch); end
         handshake_from_issue(3);
      end
      @(negedge sys_clock);
      total++; if (frames_sent !== 16'd6) begin bad++; $display("FAIL cont_frames got=%0d want=6", frames_sent); end
      req_valid = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req_valid = 3'b100;
      @(negedge sys_clock);
      tick();
      req_valid = '0;
      tick();
      repeat (254) tick();
      @(negedge sys_clock);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", timeout_err); end
      tick();
      @(negedge sys_clock);
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", timeout_err); end
      total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL tmo_frames got=%0d want=0", frames_sent); end
      repeat (5) tick();
      req_valid = 3'b010;
      tick();
      req_valid = 3'b000;
      repeat (9) tick();
      req_valid = 3'b001;
      @(negedge sys_clock);
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL tmo_gap_ready got=%b want=000", req_ready); end
      tick();
      @(negedge sys_clock);
      total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL tmo_idle_grant got=%b want=001", req_ready); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", timeout_err); end
      tick();
      req_valid = '0;
      @(negedge sys_clock);
      total++; if (o_chan !== 2'd0) begin bad++; $display("FAIL tmo_no_buffer got=%0d want=0", o_chan); end
      total++; if (o_data !== D0) begin bad++; $display("FAIL tmo_data got=%h want=%h", o_data, D0); end
   endtask

   task automatic test_reset_mid();
      int w;
      do_reset();
      req_valid = 3'b100;
      @(negedge sys_clock);
      tick();
      req_valid = '0;
      @(negedge sys_clock);
      handshake_from_issue(2);
      req_valid = 3'b010;
      wait_grant(40, w);
      total++; if (w < 0) begin bad++; $display("FAIL rmid_wait got=timeout want=grant"); end
      tick();
      req_valid = '0;
      tick();
      drv_busy = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      @(negedge sys_clock);
      total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL rmid_pre_frames got=%0d want=1", frames_sent); end
      total++; if (o_chan !== 2'd1) begin bad++; $display("FAIL rmid_pre_chan got=%0d want=1", o_chan); end
      tick();
      @(negedge sys_clock);
      total++; if (o_data !== 22'h0) begin bad++; $display("FAIL rmid_o_data got=%h want=0", o_data); end
      total++; if (o_chan !== 2'd0) begin bad++; $display("FAIL rmid_o_chan got=%0d want=0", o_chan); end
      total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL rmid_frames got=%0d want=0", frames_sent); end
      total++; if (new_frame !== 1'b0) begin bad++; $display("FAIL rmid_new_frame got=%b want=0", new_frame); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rmid_ready got=%b want=000", req_ready); end
      tick();
      reset     = 1'b0;
      drv_busy  = 1'b0;
      req_valid = 3'b111;
      @(negedge sys_clock);
      total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rmid_first_grant got=%b want=001", req_ready); end
      tick();
      req_valid = '0;
      @(negedge sys_clock);
      total++; if (new_frame !== 1'b1) begin bad++; $display("FAIL rmid_issue got=%b want=1", new_frame); end
   endtask

   task automatic test_wrap();
      do_reset();
      force dut.frames_sent = 16'hFFFF;
      #1;
      release dut.frames_sent;
      req_valid = 3'b001;
      @(negedge sys_clock);
      tick();
      req_valid = '0;
      @(negedge sys_clock);
      handshake_from_issue(2);
      @(negedge sys_clock);
      total++; if (frames_sent !== 16'h0000) begin bad++; $display("FAIL wrap got=%h want=0000", frames_sent); end
   endtask

   initial begin
      req_data = {D2, D1, D0};
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
